alu_op_sequencer: RTL and testbench

- Operand/result sequencer wrapped around the 4-bit combinational ALU.
- Accepts {opcode, A, B} commands over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head to the ALU input ports, then registers the ALU result/carry_out/zero into a backpressured output stage.
- Gives the ALU a clean sequential front and back end for the surrounding datapath.

---
 rtl/alu_op_sequencer_if.sv | 34 +++
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Command and result channels of the ALU operand/result sequencer.
//   Command channel: in_valid/in_ready handshake carrying {in_opcode, in_a, in_b}.
//   Result channel : out_valid/out_ready handshake carrying
//                    {out_result, out_carry, out_zero, out_opcode}.
//   Modports:
//     master - command producer / result consumer (surrounding datapath)
//     slave  - the sequencer itself
interface alu_op_sequencer_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;
  logic              out_zero;
  logic [2:0]        out_opcode;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_opcode
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_opcode
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sequential front/back end for the 4-bit combinational ALU. Commands
//   {opcode, A, B} are buffered in a DEPTH-entry FIFO; the FIFO head drives
//   the ALU inputs, and the ALU outputs are registered into a backpressured
//   single-entry output stage together with the head opcode.
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     flush               sync clear of FIFO and output stage (out data kept)
//     bus (slave)         command channel in_* and result channel out_*
//     alu_opcode/a/b      head entry to the ALU (zero when FIFO empty)
//     alu_result/carry/zero  ALU outputs
//     fifo_count          FIFO occupancy 0..DEPTH
//
//   Optional feature (macro ALU_SEQ_STICKY_FLAGS_EN):
//     sticky_clr in, sticky_carry/sticky_zero out - OR-accumulated flags over
//     every capture; cleared by sticky_clr (a same-cycle capture wins), not by
//     flush.
module alu_op_sequencer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  alu_op_sequencer_if.slave          bus,
  output logic [2:0]                 alu_opcode,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  input  logic                       sticky_clr,
  output logic                       sticky_carry,
  output logic                       sticky_zero,
`endif
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } out_state_t;

  out_state_t state, state_nxt;

  logic [2:0]        mem_op [DEPTH];
  logic [DATA_W-1:0] mem_a  [DEPTH];
  logic [DATA_W-1:0] mem_b  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              fifo_empty;
  logic              fifo_full;
  logic              out_valid;
  logic              push_en;
  logic              capture;
  logic              capture_en;

  logic [DATA_W-1:0] out_result_q;
  logic              out_carry_q;
  logic              out_zero_q;
  logic [2:0]        out_opcode_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign out_valid  = (state == S_FULL);

  // Capture is the raw pop opportunity; flush suppresses both push and pop so
  // the FIFO clears cleanly and the output registers keep their last data.
  assign capture    = !fifo_empty && (!out_valid || bus.out_ready);
  assign capture_en = capture && !flush;
  assign push_en    = bus.in_valid && !fifo_full && !flush;

  assign bus.in_ready   = !fifo_full;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_opcode = out_opcode_q;
  assign fifo_count     = count;

  // ALU drive from the FIFO head
  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (!fifo_empty) begin
      alu_opcode = mem_op[rd_ptr];
      alu_a      = mem_a[rd_ptr];
      alu_b      = mem_b[rd_ptr];
    end
  end

  // FIFO storage (data only; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_op[wr_ptr] <= bus.in_opcode;
      mem_a[wr_ptr]  <= bus.in_a;
      mem_b[wr_ptr]  <= bus.in_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (capture_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, capture_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Output-stage FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (capture) state_nxt = S_FULL;
      S_FULL:  if (bus.out_ready && !capture) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Output-stage data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_opcode_q <= '0;
    end else if (capture_en) begin
      out_result_q <= alu_result;
      out_carry_q  <= alu_carry;
      out_zero_q   <= alu_zero;
      out_opcode_q <= alu_opcode;
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  // Clear first, then OR in the current capture so a setting capture wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry <= 1'b0;
      sticky_zero  <= 1'b0;
    end else begin
      sticky_carry <= (sticky_clr ? 1'b0 : sticky_carry) | (capture_en & alu_carry);
      sticky_zero  <= (sticky_clr ? 1'b0 : sticky_zero)  | (capture_en & alu_zero);
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic clk;
  logic rst_n;
  logic flush;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic sticky_clr;
  logic sticky_carry;
  logic sticky_zero;
`endif

  int tests_run;
  int tests_failed;

  alu_op_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_op_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_carry (sticky_carry),
    .sticky_zero  (sticky_zero),
`endif
    .fifo_count   (fifo_count)
  );

  // Behavioural 4-bit ALU; carry on SUB is the borrow out.
  always_comb begin
    logic [DATA_W:0] wide;
    wide = '0;
    case (alu_opcode)
      3'b000:  wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  wide = {1'b0, alu_a & alu_b};
      3'b011:  wide = {1'b0, alu_a | alu_b};
      3'b100:  wide = {1'b0, alu_a ^ alu_b};
      3'b101:  wide = {1'b0, ~(alu_a & alu_b)};
      3'b110:  wide = {1'b0, ~(alu_a | alu_b)};
      default: wide = {{DATA_W{1'b0}}, (alu_a < alu_b)};
    endcase
    alu_result = wide[DATA_W-1:0];
    alu_carry  = wide[DATA_W];
    alu_zero   = (wide[DATA_W-1:0] == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      output logic acc);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    acc = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic acc;
  int   n_acc;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    sticky_clr    = 1'b0;
`endif
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_result", 32'(bus.out_result), 0);
    check("rst_alu_a_empty", 32'(alu_a), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD 9+8: result 1, carry 1, one edge after acceptance
    push(OP_ADD, 4'h9, 4'h8, acc);
    check("add_count", 32'(fifo_count), 1);
    check("add_not_yet", 32'(bus.out_valid), 0);
    check("add_alu_a", 32'(alu_a), 32'h9);
    tick();
    check("add_valid", 32'(bus.out_valid), 1);
    check("add_result", 32'(bus.out_result), 32'h1);
    check("add_carry", 32'(bus.out_carry), 1);
    check("add_zero", 32'(bus.out_zero), 0);
    check("add_opcode", 32'(bus.out_opcode), 32'(OP_ADD));
    tick();
    check("add_drain", 32'(bus.out_valid), 0);

    // SUB 3-5 then SLT 2<7 back-to-back
    push(OP_SUB, 4'h3, 4'h5, acc);
    push(OP_SLT, 4'h2, 4'h7, acc);
    check("sub_result", 32'(bus.out_result), 32'hE);
    check("sub_carry", 32'(bus.out_carry), 1);
    check("sub_zero", 32'(bus.out_zero), 0);
    check("sub_opcode", 32'(bus.out_opcode), 32'(OP_SUB));
    tick();
    check("slt_valid", 32'(bus.out_valid), 1);
    check("slt_result", 32'(bus.out_result), 32'h1);
    check("slt_carry", 32'(bus.out_carry), 0);
    check("slt_opcode", 32'(bus.out_opcode), 32'(OP_SLT));
    tick();

    // Capacity with out_ready low: 6 offered, 5 accepted; results i+1 in order
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(OP_ADD, 4'(i), 4'h1, acc);
      if (acc) n_acc++;
    end
    check("cap_accepted", 32'(n_acc), 5);
    check("cap_in_ready", 32'(bus.in_ready), 0);
    check("cap_count", 32'(fifo_count), 4);
    check("cap_held", 32'(bus.out_result), 32'h1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("order_valid", 32'(bus.out_valid), 1);
      check("order_result", 32'(bus.out_result), 32'(k + 1));
      tick();
    end
    check("order_count", 32'(fifo_count), 0);
    check("order_idle", 32'(bus.out_valid), 0);

    // Full FIFO + flush with in_valid high
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(OP_ADD, 4'(i + 3), 4'(i + 3), acc);
    check("fill_count", 32'(fifo_count), 4);
    flush = 1'b1;
    push(OP_ADD, 4'h7, 4'h7, acc);
    flush = 1'b0;
    check("flush_count", 32'(fifo_count), 0);
    check("flush_valid", 32'(bus.out_valid), 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    check("flush_keeps_data", 32'(bus.out_result), 32'h6);
    // flush beats a push into a non-full FIFO
    bus.out_ready = 1'b1;
    flush = 1'b1;
    push(OP_ADD, 4'h7, 4'h7, acc);
    flush = 1'b0;
    check("flush_push_count", 32'(fifo_count), 0);
    tick();
    check("flush_push_dropped", 32'(bus.out_valid), 0);

    // AND 5 & A -> zero
    push(OP_AND, 4'h5, 4'hA, acc);
    tick();
    check("and_result", 32'(bus.out_result), 0);
    check("and_zero", 32'(bus.out_zero), 1);
    check("and_carry", 32'(bus.out_carry), 0);

    // Async reset mid-stream
    bus.out_ready = 1'b0;
    push(OP_ADD, 4'h1, 4'h1, acc);
    push(OP_ADD, 4'h2, 4'h2, acc);
    push(OP_ADD, 4'h3, 4'h3, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_result", 32'(bus.out_result), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("arst_no_residue", 32'(bus.out_valid), 0);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    check("sticky_rst_c", 32'(sticky_carry), 0);
    check("sticky_rst_z", 32'(sticky_zero), 0);
    push(OP_XOR, 4'hF, 4'hF, acc);
    tick();
    check("sticky_z_set", 32'(sticky_zero), 1);
    check("sticky_c_clear", 32'(sticky_carry), 0);
    push(OP_ADD, 4'hF, 4'h1, acc);
    tick();
    check("sticky_c_set", 32'(sticky_carry), 1);
    check("sticky_z_held", 32'(sticky_zero), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sticky_flush_c", 32'(sticky_carry), 1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr_c", 32'(sticky_carry), 0);
    check("sticky_clr_z", 32'(sticky_zero), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
